// File: rtl/plab4_net_router_input_queue_sep.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : plab4_net_router_input_queue_sep
// Brief   : Router input queue with one private circular FIFO per security
//           domain. Inbound flits are steered by their domain bit; each FIFO
//           presents its head flit, valid and destination to the arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module plab4_net_router_input_queue_sep #(
  parameter  int p_msg_nbits   = 44,
  parameter  int p_num_routers = 8,
  parameter  int p_num_entries = 2,
  parameter  int p_dest_msb    = 43,
  localparam int c_dest_nbits  = $clog2(p_num_routers),
  localparam int c_cnt_nbits   = $clog2(p_num_entries + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [p_msg_nbits-1:0]  in_msg,
  input  logic                    in_domain,
  input  logic                    in_val,
  output logic                    in_rdy,
  output logic [p_msg_nbits-1:0]  out_msg_d1,
  output logic                    out_val_d1,
  input  logic                    out_rdy_d1,
  output logic [c_dest_nbits-1:0] dest_d1,
  output logic [p_msg_nbits-1:0]  out_msg_d2,
  output logic                    out_val_d2,
  input  logic                    out_rdy_d2,
  output logic [c_dest_nbits-1:0] dest_d2
);

  // A depth-1 queue still needs a 1-bit pointer to index its single slot.
  localparam int c_ptr_nbits = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam logic [c_ptr_nbits-1:0] c_last_ptr = c_ptr_nbits'(p_num_entries - 1);
  localparam logic [c_cnt_nbits-1:0] c_full_cnt = c_cnt_nbits'(p_num_entries);

  logic [c_cnt_nbits-1:0] w_count    [2];
  logic [p_msg_nbits-1:0] w_head_msg [2];
  logic [1:0]             w_out_rdy;
  logic                   w_in_rdy;

  assign w_out_rdy = {out_rdy_d2, out_rdy_d1};

  // Acceptance looks only at the selected queue's registered count, so a
  // dequeue in the same cycle never frees a slot for the incoming flit.
  assign w_in_rdy = in_domain ? (w_count[1] != c_full_cnt)
                              : (w_count[0] != c_full_cnt);
  assign in_rdy   = w_in_rdy;

  for (genvar d = 0; d < 2; d++) begin : g_dom
    logic [p_msg_nbits-1:0] mem_q [p_num_entries];
    logic [c_ptr_nbits-1:0] head_q, head_d;
    logic [c_ptr_nbits-1:0] tail_q, tail_d;
    logic [c_cnt_nbits-1:0] count_q, count_d;
    logic                   w_enq;
    logic                   w_deq;

    assign w_enq = in_val && w_in_rdy && (in_domain == 1'(d));
    assign w_deq = (count_q != '0) && w_out_rdy[d];

    // Next-state pointers and occupancy; explicit wrap handles any depth.
    always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (w_enq) begin
        tail_d = (tail_q == c_last_ptr) ? '0 : tail_q + 1'b1;
      end
      if (w_deq) begin
        head_d = (head_q == c_last_ptr) ? '0 : head_q + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // Pointer and count registers; reset discards all queued flits.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
      end
    end

    // Flit storage; contents are only meaningful under a valid count.
    always_ff @(posedge clk) begin
      if (w_enq) begin
        mem_q[tail_q] <= in_msg;
      end
    end

    assign w_head_msg[d] = (count_q != '0) ? mem_q[head_q] : '0;
    assign w_count[d]    = count_q;
  end

  assign out_msg_d1 = w_head_msg[0];
  assign out_val_d1 = (w_count[0] != '0);
  assign dest_d1    = w_head_msg[0][p_dest_msb -: c_dest_nbits];

  assign out_msg_d2 = w_head_msg[1];
  assign out_val_d2 = (w_count[1] != '0);
  assign dest_d2    = w_head_msg[1][p_dest_msb -: c_dest_nbits];

endmodule
`default_nettype wire

// File: tb/tb_plab4_net_router_input_queue_sep.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_plab4_net_router_input_queue_sep
// Brief   : Bench driving a depth-2 and a depth-3 queue with shared stimulus,
//           each checked every cycle against per-domain flit queues.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_plab4_net_router_input_queue_sep;

  logic        clk = 1'b0;
  logic        reset;
  logic [43:0] in_msg;
  logic        in_domain;
  logic        in_val;
  logic        rdy1;
  logic        rdy2;

  logic        a_in_rdy, a_val1, a_val2;
  logic [43:0] a_msg1, a_msg2;
  logic [2:0]  a_dest1, a_dest2;
  logic        b_in_rdy, b_val1, b_val2;
  logic [43:0] b_msg1, b_msg2;
  logic [2:0]  b_dest1, b_dest2;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Expected contents of each domain queue, oldest first.
  logic [43:0] ma1 [$];
  logic [43:0] ma2 [$];
  logic [43:0] mb1 [$];
  logic [43:0] mb2 [$];

  always #5 clk = ~clk;

  plab4_net_router_input_queue_sep #(.p_num_entries(2)) u_dut_a (
    .clk(clk), .reset(reset), .in_msg(in_msg), .in_domain(in_domain),
    .in_val(in_val), .in_rdy(a_in_rdy),
    .out_msg_d1(a_msg1), .out_val_d1(a_val1), .out_rdy_d1(rdy1), .dest_d1(a_dest1),
    .out_msg_d2(a_msg2), .out_val_d2(a_val2), .out_rdy_d2(rdy2), .dest_d2(a_dest2)
  );

  plab4_net_router_input_queue_sep #(.p_num_entries(3)) u_dut_b (
    .clk(clk), .reset(reset), .in_msg(in_msg), .in_domain(in_domain),
    .in_val(in_val), .in_rdy(b_in_rdy),
    .out_msg_d1(b_msg1), .out_val_d1(b_val1), .out_rdy_d1(rdy1), .dest_d1(b_dest1),
    .out_msg_d2(b_msg2), .out_val_d2(b_val2), .out_rdy_d2(rdy2), .dest_d2(b_dest2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [43:0] head(input int sz, input logic [43:0] h);
    return (sz != 0) ? h : 44'd0;
  endfunction

  // Model: a flit is accepted when its queue holds fewer than depth flits,
  // a head leaves when its queue is non-empty and its consumer is ready.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma1.delete(); ma2.delete(); mb1.delete(); mb2.delete();
    end else begin
      bit acc_a, acc_b, da1, da2, db1, db2;
      acc_a = in_val && ((in_domain ? ma2.size() : ma1.size()) != 2);
      acc_b = in_val && ((in_domain ? mb2.size() : mb1.size()) != 3);
      da1 = (ma1.size() != 0) && rdy1;
      da2 = (ma2.size() != 0) && rdy2;
      db1 = (mb1.size() != 0) && rdy1;
      db2 = (mb2.size() != 0) && rdy2;
      if (da1) void'(ma1.pop_front());
      if (da2) void'(ma2.pop_front());
      if (db1) void'(mb1.pop_front());
      if (db2) void'(mb2.pop_front());
      if (acc_a) begin
        if (in_domain) ma2.push_back(in_msg); else ma1.push_back(in_msg);
      end
      if (acc_b) begin
        if (in_domain) mb2.push_back(in_msg); else mb1.push_back(in_msg);
      end
    end
  end

  // Compare both DUTs against the model mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [43:0] e;
      chk("a_in_rdy", a_in_rdy, ((in_domain ? ma2.size() : ma1.size()) != 2));
      chk("a_val1", a_val1, ma1.size() != 0);
      chk("a_val2", a_val2, ma2.size() != 0);
      e = head(ma1.size(), (ma1.size() != 0) ? ma1[0] : 44'd0);
      chk("a_msg1", a_msg1, e);
      chk("a_dest1", a_dest1, e[43:41]);
      e = head(ma2.size(), (ma2.size() != 0) ? ma2[0] : 44'd0);
      chk("a_msg2", a_msg2, e);
      chk("a_dest2", a_dest2, e[43:41]);
      chk("b_in_rdy", b_in_rdy, ((in_domain ? mb2.size() : mb1.size()) != 3));
      chk("b_val1", b_val1, mb1.size() != 0);
      chk("b_val2", b_val2, mb2.size() != 0);
      e = head(mb1.size(), (mb1.size() != 0) ? mb1[0] : 44'd0);
      chk("b_msg1", b_msg1, e);
      chk("b_dest1", b_dest1, e[43:41]);
      e = head(mb2.size(), (mb2.size() != 0) ? mb2[0] : 44'd0);
      chk("b_msg2", b_msg2, e);
      chk("b_dest2", b_dest2, e[43:41]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [43:0] fa, fb, fc, fd;
    fa = 44'h1A0_0000_00AA;
    fb = 44'h2B0_0000_00BB;
    fc = 44'h3C0_0000_00CC;
    fd = 44'h4D0_0000_00DD;
    reset = 1'b1; in_msg = '0; in_domain = 1'b0; in_val = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Reset held with a valid flit offered: nothing may enqueue.
    in_val = 1'b1; in_msg = fa;
    repeat (3) cyc();
    chk("rst_in_rdy", a_in_rdy, 1'b1);
    chk("rst_val1", a_val1, 1'b0);
    chk("rst_val2", a_val2, 1'b0);
    chk("rst_msg1", a_msg1, 44'd0);
    in_val = 1'b0;
    reset = 1'b1;
    cyc();
    chk("rst_after_val1", a_val1, 1'b0);

    // Single flit into domain 2 with destination 5.
    in_val = 1'b1; in_domain = 1'b1; in_msg = {3'd5, 41'h0_1234_5678};
    cyc();
    in_val = 1'b0;
    chk("single_val2", a_val2, 1'b1);
    chk("single_dest2", a_dest2, 3'd5);
    chk("single_val1", a_val1, 1'b0);
    rdy2 = 1'b1;
    cyc();
    rdy2 = 1'b0;
    chk("single_drained", a_val2, 1'b0);
    chk("single_msg_zero", a_msg2, 44'd0);

    // Isolation: fill domain 1 with A,B; domain 2 still accepts C.
    in_val = 1'b1; in_domain = 1'b0; in_msg = fa;
    cyc();
    in_msg = fb;
    cyc();
    in_val = 1'b0;
    chk("iso_rdy_d1_full", a_in_rdy, 1'b0);
    in_domain = 1'b1;
    #1;
    chk("iso_rdy_d2_open", a_in_rdy, 1'b1);
    in_val = 1'b1; in_msg = fc;
    cyc();
    in_val = 1'b0;
    chk("iso_msg2_c", a_msg2, fc);
    chk("iso_msg1_a", a_msg1, fa);

    // Full queue with same-cycle dequeue: no bypass into the freed slot.
    in_domain = 1'b0; in_val = 1'b1; in_msg = fd; rdy1 = 1'b1;
    #1;
    chk("full_deq_rdy", a_in_rdy, 1'b0);
    cyc();
    in_val = 1'b0; rdy1 = 1'b0;
    chk("full_deq_head_b", a_msg1, fb);
    chk("full_deq_model_cnt", ma1.size(), 1);
    chk("full_deq_b_depth3", mb1.size(), 2);

    // Drain everything.
    rdy1 = 1'b1; rdy2 = 1'b1;
    repeat (4) cyc();
    rdy1 = 1'b0; rdy2 = 1'b0;

    // Reset mid-stream with two flits in each queue.
    in_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_domain = i[1];
      in_msg = {12'($urandom), $urandom};
      cyc();
    end
    in_val = 1'b0;
    chk("mid_pre_val1", a_val1, 1'b1);
    chk("mid_pre_val2", a_val2, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_val1", a_val1, 1'b0);
    chk("mid_rst_val2", a_val2, 1'b0);
    chk("mid_rst_b_val2", b_val2, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rel_in_rdy", a_in_rdy, 1'b1);
    cyc();

    // Random traffic: slow consumers first (queues fill), then fast ones.
    for (int i = 0; i < 3000; i++) begin
      in_val    = ($urandom_range(0, 3) != 0);
      in_domain = 1'($urandom);
      in_msg    = {12'($urandom), $urandom};
      if (i < 1500) begin
        rdy1 = ($urandom_range(0, 2) == 0);
        rdy2 = ($urandom_range(0, 2) == 0);
      end else begin
        rdy1 = ($urandom_range(0, 3) != 0);
        rdy2 = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end
    in_val = 1'b0; rdy1 = 1'b1; rdy2 = 1'b1;
    repeat (5) cyc();
    chk("end_empty_a", {a_val1, a_val2}, 2'b00);
    chk("end_empty_b", {b_val1, b_val2}, 2'b00);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/plab4_net_router_input_queue_sep.md
# plab4_net_router_input_queue_sep

Per-port, domain-separated input queue for the secure mesh router. Sits directly upstream of the separated input-control arbiter: it accepts flits from the inbound channel, steers each into a private FIFO selected by the flit's domain bit, and presents each FIFO's head message, valid and destination field to the arbiter's per-domain inputs. Separate storage guarantees that backpressure or occupancy in one domain never blocks or reorders the other domain's traffic.

## Interface
- p_msg_nbits, 44: flit width in bits.
- p_num_routers, 8: routers in the ring; sets destination width.
- p_num_entries, 2: FIFO depth per domain, ≥1, need not be a power of two.
- p_dest_msb, 43: MSB index of the destination field inside a flit.
- c_dest_nbits, $clog2(p_num_routers): derived, not set externally.
- c_cnt_nbits, $clog2(p_num_entries+1): derived occupancy-counter width.

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_msg  input  p_msg_nbits  inbound flit.
- in_domain  input  1  0 = domain 1 queue, 1 = domain 2 queue.
- in_val  input  1  inbound flit valid.
- in_rdy  output  1  selected domain queue can accept.
- out_msg_d1  output  p_msg_nbits  domain-1 head flit.
- out_val_d1  output  1  domain-1 queue non-empty.
- out_rdy_d1  input  1  domain-1 consumer accepts head.
- dest_d1  output  c_dest_nbits  out_msg_d1[p_dest_msb -: c_dest_nbits].
- out_msg_d2, out_val_d2, out_rdy_d2, dest_d2: identical set for domain 2.

## Operation
- Two independent circular FIFOs, each with head pointer, tail pointer (0..p_num_entries-1) and count (0..p_num_entries).
- in_rdy = (count of queue selected by in_domain) != p_num_entries; combinational on in_domain and that count only.
- Enqueue: in_val && in_rdy writes in_msg at tail of the selected queue; tail advances, count +1. The non-selected queue is untouched.
- Dequeue per domain: out_val_dX && out_rdy_dX; head advances, count −1.
- Same-domain enqueue and dequeue in one cycle: both occur, count unchanged.
- Full queue: in_rdy = 0 for that domain even if a dequeue happens the same cycle (no pipe bypass). Other domain's in_rdy is unaffected.
- Empty queue: out_val_dX = 0, out_msg_dX and dest_dX driven to all zeros; no flow-through bypass.
- out_val_dX = (count_dX != 0); out_msg_dX = storage[head_dX] when non-empty.
- Pointer wrap: pointer equal to p_num_entries-1 advances to 0; correct for non-power-of-two depth.
- in_rdy and out_* never depend on out_rdy_dX (no combinational in→out path), avoiding loops with the arbiter.
- FIFO order within a domain strictly preserved; no ordering between domains implied.

## Timing
- Reset (reset low, asynchronous): all pointers and counts to 0; out_val_d1 = out_val_d2 = 0, out_msg/dest outputs 0, in_rdy = 1. Storage array not reset.
- Reset asserted mid-operation: all queued flits discarded immediately; no flit is presented after reset deasserts until newly enqueued.
- Latency: flit enqueued at edge N is visible on out_val_dX/out_msg_dX after edge N (one cycle).
- Throughput: one enqueue per cycle total and one dequeue per cycle per domain.
- Outputs are registered-state derived (count/head), stable for the whole cycle.

## Test plan
- Reset: hold reset low, drive in_val=1 -> in_rdy=1, out_val_d1=out_val_d2=0, outputs 0; nothing enqueued while reset low.
- Single flit: in_domain=1, in_msg with dest=5 -> next cycle out_val_d2=1, dest_d2=5, out_val_d1=0; pulse out_rdy_d2 -> out_val_d2=0.
- Isolation: depth 2, fill domain 1 with A,B (out_rdy_d1=0) -> in_rdy=0 for in_domain=0, in_rdy=1 for in_domain=1; domain-2 flit C enqueues and appears on out_msg_d2 while A stays at domain-1 head.
- Full + simultaneous dequeue: domain 1 full, out_rdy_d1=1 and in_val=1,in_domain=0 -> A dequeued, new flit not accepted (in_rdy=0), count becomes 1.
- Wrap with depth 3: stream 10 flits into domain 2 with random out_rdy_d2 -> output order equals input order, no loss or duplication.
- Reset mid-stream: both queues holding 2 flits, pulse reset low for half a cycle -> out_val_d1=out_val_d2=0 immediately, in_rdy=1 after release.
